// File: rtl/uso_del_pll_ip_core.sv
`timescale 1ns/1ps
// Behavioural PLL stand-in: gates clk100 down to clk10 once a fixed lock delay has
// elapsed, and drives a heartbeat LED from the derived clock.
module uso_del_pll_ip_core #(
  parameter int DIV         = 10,
  parameter int LOCK_CYCLES = 64,
  parameter int BLINK_HALF  = 5_000_000
) (
  input  logic clk100,
  input  logic rst,
  output logic led
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int PW = $clog2(DIV + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_CYCLES);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_lock_cnt_nxt;
  logic          locked;
  logic          w_locked_nxt;
  logic [PW-1:0] r_phase_cnt;
  logic [PW-1:0] w_phase_nxt;
  logic          r_en;
  logic          w_en_nxt;
  logic          clk10;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_nxt;
  logic          r_led;
  logic          w_led_nxt;

  // Lock counter saturates; locked is sticky until the next reset.
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    w_locked_nxt   = locked;
    if (r_lock_cnt < LOCK_MAX) begin
      w_lock_cnt_nxt = r_lock_cnt + LW'(1);
    end else begin
      w_lock_cnt_nxt = r_lock_cnt;
    end
    if (w_lock_cnt_nxt == LOCK_MAX) begin
      w_locked_nxt = 1'b1;
    end else begin
      w_locked_nxt = locked;
    end
  end

  // Phase counter next value, parked at zero until lock.
  always_comb begin
    w_phase_nxt = r_phase_cnt;
    if (!locked) begin
      w_phase_nxt = {PW{1'b0}};
    end else if (r_phase_cnt == PHASE_LAST) begin
      w_phase_nxt = {PW{1'b0}};
    end else begin
      w_phase_nxt = r_phase_cnt + PW'(1);
    end
  end

  // Gate enable value captured on the falling edge.
  always_comb begin
    w_en_nxt = 1'b0;
    if (locked && (r_phase_cnt == {PW{1'b0}})) begin
      w_en_nxt = 1'b1;
    end else begin
      w_en_nxt = 1'b0;
    end
  end

  // Lock and divider state on clk100 rising edges.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      r_lock_cnt  <= {LW{1'b0}};
      locked      <= 1'b0;
      r_phase_cnt <= {PW{1'b0}};
    end else begin
      r_lock_cnt  <= w_lock_cnt_nxt;
      locked      <= w_locked_nxt;
      r_phase_cnt <= w_phase_nxt;
    end
  end

  // Enable changes only while clk100 is low, so the AND gate below cannot glitch.
  always_ff @(negedge clk100 or negedge rst) begin
    if (!rst) begin
      r_en <= 1'b0;
    end else begin
      r_en <= w_en_nxt;
    end
  end

  assign clk10 = clk100 & r_en;

  // Blink counter and LED toggle decision.
  always_comb begin
    w_blink_nxt = r_blink_cnt;
    w_led_nxt   = r_led;
    if (r_blink_cnt == BLINK_LAST) begin
      w_blink_nxt = {BW{1'b0}};
      w_led_nxt   = ~r_led;
    end else begin
      w_blink_nxt = r_blink_cnt + BW'(1);
      w_led_nxt   = r_led;
    end
  end

  // Heartbeat state in the clk10 domain.
  always_ff @(posedge clk10 or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= {BW{1'b0}};
      r_led       <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_nxt;
      r_led       <= w_led_nxt;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_uso_del_pll_ip_core.sv
`timescale 1ns/1ps
// Self-checking bench for uso_del_pll_ip_core: vector table with a reference model,
// plus hand-written lock, period, blink and mid-run reset sequences.
module tb_uso_del_pll_ip_core;

  localparam int DIV  = 10;
  localparam int LOCK = 64;
  localparam int BH   = 4;

  logic clk100 = 1'b0;
  logic rst;
  logic led;

  int checks = 0;
  int errors = 0;
  int pulse_cnt;

  uso_del_pll_ip_core #(.DIV(DIV), .LOCK_CYCLES(LOCK), .BLINK_HALF(BH)) dut (
    .clk100 (clk100),
    .rst    (rst),
    .led    (led)
  );

  always #5 clk100 = ~clk100;

  // Count clk10 rising edges since the last reset release.
  always @(posedge dut.clk10 or negedge rst) begin
    if (!rst) pulse_cnt <= 0;
    else      pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    int hold;
    int run;
    int exp_locked;
    int exp_pulses;
    int exp_clk10;
    int exp_led;
  } vec_t;

  // Reference model: state after n clk100 rising edges since reset release.
  function automatic int m_locked(int n);
    return (n >= LOCK) ? 1 : 0;
  endfunction
  function automatic int m_pulses(int n);
    return (n <= LOCK) ? 0 : ((n - LOCK - 1) / DIV + 1);
  endfunction
  function automatic int m_clk10(int n);
    return (n > LOCK && ((n - LOCK - 1) % DIV) == 0) ? 1 : 0;
  endfunction
  function automatic int m_led(int p);
    return (p / BH) % 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input real act, input real lo, input real hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0.3f required=%0.3f..%0.3f", name, act, lo, hi);
    end
  endtask

  // Poll clk100 edges until clk10 is seen high; bounded.
  task automatic wait_clk10(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(posedge clk100);
      #1;
      if (dut.clk10) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("clk10_timeout", 0, 1);
  endtask

  // Release reset and count edges until lock, with a 200 us bound.
  task automatic lock_from_reset();
    int n;
    n = 0;
    @(negedge clk100);
    rst = 1'b1;
    while (!dut.locked && n < 20000) begin
      @(posedge clk100);
      #1;
      n++;
    end
    chk("lock_edges", n, LOCK);
    chk("no_pulse_before_lock", pulse_cnt, 0);
  endtask

  task automatic check_periods();
    bit  ok;
    real t0;
    for (int i = 0; i < 10; i++) wait_clk10(ok);
    t0 = $realtime;
    for (int i = 0; i < 5; i++) begin
      wait_clk10(ok);
      chk_range("clk10_period_ns", $realtime - t0, 98.0, 102.0);
      t0 = $realtime;
    end
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    bit  ok;
    int  n;
    int  lv;
    real t_tog;
    real t_prev;

    rst = 1'b1;
    #1 rst = 1'b0;

    // Test 1: reset held for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk100);
      #1;
      chk("rst_led", led, 0);
      chk("rst_locked", dut.locked, 0);
      chk("rst_clk10", dut.clk10, 0);
    end

    // Test 2 and 3: lock latency and clk10 period.
    lock_from_reset();
    check_periods();

    // Test 4: exactly DIV clk100 edges between clk10 rising edges.
    for (int k = 0; k < 4; k++) begin
      wait_clk10(ok);
      n = 0;
      for (int i = 0; i < 3 * DIV; i++) begin
        @(posedge clk100);
        #1;
        n++;
        if (dut.clk10) break;
      end
      chk("edges_per_clk10", n, DIV);
    end

    // Test 5: LED toggles every BH clk10 cycles.
    lv = led;
    t_prev = -1.0;
    for (int i = 0; i < 6 * BH && t_prev < 0.0; i++) begin
      wait_clk10(ok);
      if (led != lv) begin
        lv = led;
        t_prev = $realtime;
      end
    end
    for (int k = 0; k < 2; k++) begin
      t_tog = -1.0;
      for (int i = 0; i < 3 * BH && t_tog < 0.0; i++) begin
        wait_clk10(ok);
        if (led != lv) begin
          lv = led;
          t_tog = $realtime;
        end
      end
      chk_range("led_half_period_ns", t_tog - t_prev, 399.0, 401.0);
      t_prev = t_tog;
    end

    // Test 6: reset mid-run while clk10 and led are high.
    rst = 1'b0;
    repeat (2) @(negedge clk100);
    lock_from_reset();
    for (int i = 0; i < 5; i++) wait_clk10(ok);
    chk("pulses_before_midreset", pulse_cnt, 5);
    chk("led_before_midreset", led, m_led(5));
    chk("clk10_before_midreset", dut.clk10, 1);
    rst = 1'b0;
    #1;
    chk("midreset_clk10", dut.clk10, 0);
    chk("midreset_locked", dut.locked, 0);
    chk("midreset_led", led, 0);
    repeat (3) @(posedge clk100);
    lock_from_reset();
    check_periods();

    // Vector table: fixed corner rows, then randomized rows from the model.
    vecs.push_back('{4,  63, 0, 0, 0, 0});
    vecs.push_back('{2,  64, 1, 0, 0, 0});
    vecs.push_back('{3,  65, 1, 1, 1, 0});
    vecs.push_back('{1,  66, 1, 1, 0, 0});
    vecs.push_back('{2,  75, 1, 2, 1, 0});
    vecs.push_back('{2,  95, 1, 4, 1, 1});
    vecs.push_back('{2, 104, 1, 4, 0, 1});
    vecs.push_back('{2, 135, 1, 8, 1, 0});
    vecs.push_back('{1,   1, 0, 0, 0, 0});
    for (int i = 0; i < 8; i++) begin
      v.hold = int'($urandom_range(1, 5));
      v.run  = int'($urandom_range(1, 300));
      v.exp_locked = m_locked(v.run);
      v.exp_pulses = m_pulses(v.run);
      v.exp_clk10  = m_clk10(v.run);
      v.exp_led    = m_led(v.exp_pulses);
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      v = vecs[i];
      rst = 1'b0;
      #1;
      chk("vec_async_clk10", dut.clk10, 0);
      chk("vec_async_locked", dut.locked, 0);
      chk("vec_async_led", led, 0);
      repeat (v.hold) @(negedge clk100);
      rst = 1'b1;
      repeat (v.run) @(posedge clk100);
      #1;
      chk("vec_locked", dut.locked, v.exp_locked);
      chk("vec_pulses", pulse_cnt, v.exp_pulses);
      chk("vec_clk10", dut.clk10, v.exp_clk10);
      chk("vec_led", led, v.exp_led);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
